// File: rtl/digit_tile_fetch.sv
// Tile-mapped digit fetch: a 16x16 store of 4-bit digit codes, read in raster order for a digit ROM.
// Defining DIGIT_TILE_CLEAR_EN adds the full-screen clear engine (busy / clr_done).
module digit_tile_fetch #(
  parameter int COLS = 16,
  parameter int ROWS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       wr_en,
  input  logic [3:0] wr_col,
  input  logic [3:0] wr_row,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  input  logic       clr_req,
  input  logic [3:0] clr_value,
  output logic       busy,
  output logic       clr_done,
  output logic [3:0] digit,
  output logic [2:0] digit_yoff,
  output logic [2:0] digit_xoff,
  output logic       tile_on
);

  localparam logic [4:0] COLS_LIM = 5'(COLS);
  localparam logic [4:0] ROWS_LIM = 5'(ROWS);

  logic [3:0] tiles [256];
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_data;
  logic       clr_we;
  logic [7:0] clr_addr;
  logic [3:0] clr_val;
  logic       wr_in_range;
  logic       unused_bits;

  // Only the 2x-scaled glyph bits and the tile index are needed from the counters.
  assign unused_bits = ^{hpos[8], hpos[0], vpos[8], vpos[0]};

  assign wr_ready    = !busy;
  assign wr_in_range = ({1'b0, wr_row} < ROWS_LIM) && ({1'b0, wr_col} < COLS_LIM);

`ifdef DIGIT_TILE_CLEAR_EN
  localparam logic [3:0] COL_LAST = 4'(COLS - 1);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state;
  logic [3:0] clr_row;
  logic [3:0] clr_col;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      clr_row  <= '0;
      clr_col  <= '0;
      clr_val  <= '0;
    end else begin
      clr_done <= 1'b0;
      if (state == IDLE) begin
        if (clr_req) begin
          state   <= CLEAR;
          busy    <= 1'b1;
          clr_val <= clr_value;
          clr_row <= '0;
          clr_col <= '0;
        end
      end else begin
        if (clr_col == COL_LAST) begin
          clr_col <= '0;
          if (clr_row == ROW_LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            clr_row  <= '0;
          end else begin
            clr_row <= clr_row + 4'd1;
          end
        end else begin
          clr_col <= clr_col + 4'd1;
        end
      end
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = {clr_row, clr_col};
`else
  logic unused_clr;

  assign unused_clr = ^{clr_req, clr_value};
  assign busy       = 1'b0;
  assign clr_done   = 1'b0;
  assign clr_we     = 1'b0;
  assign clr_addr   = '0;
  assign clr_val    = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (clr_we) begin
      mem_we   = 1'b1;
      mem_addr = clr_addr;
      mem_data = clr_val;
    end else if (wr_en && wr_ready && wr_in_range) begin
      mem_we   = 1'b1;
      mem_addr = {wr_row, wr_col};
      mem_data = wr_data;
    end
  end

  // NOTE: the tile store is deliberately not reset; it must survive a reset and maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) tiles[mem_addr] <= mem_data;
  end

  // The read samples the array before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit      <= '0;
      digit_yoff <= '0;
      digit_xoff <= '0;
      tile_on    <= 1'b0;
    end else begin
      digit      <= tiles[{vpos[7:4], hpos[7:4]}];
      digit_yoff <= vpos[3:1];
      digit_xoff <= hpos[3:1];
      tile_on    <= display_on;
    end
  end

endmodule

// File: tb/tb_digit_tile_fetch.sv
// Self-checking bench for digit_tile_fetch: vector table, raster sweep, randomized model compare and clear scenarios.
`timescale 1ns/1ps
module tb_digit_tile_fetch;

  localparam int COLS = 16;
  localparam int ROWS = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic       display_on = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_col = '0;
  logic [3:0] wr_row = '0;
  logic [3:0] wr_data = '0;
  logic       wr_ready;
  logic       clr_req = 1'b0;
  logic [3:0] clr_value = '0;
  logic       busy;
  logic       clr_done;
  logic [3:0] digit;
  logic [2:0] digit_yoff;
  logic [2:0] digit_xoff;
  logic       tile_on;

  digit_tile_fetch #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_req(clr_req), .clr_value(clr_value), .busy(busy), .clr_done(clr_done),
    .digit(digit), .digit_yoff(digit_yoff), .digit_xoff(digit_xoff), .tile_on(tile_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    logic [3:0] wr_data;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       disp;
    logic [3:0] exp_digit;
    logic [2:0] exp_xoff;
    logic [2:0] exp_yoff;
    logic       exp_on;
  } vec_t;

  vec_t vecs[11];
  int   model [ROWS][COLS];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input int r, input int c, input int d);
    wr_en   = 1'b1;
    wr_row  = 4'(r);
    wr_col  = 4'(c);
    wr_data = 4'(d);
    tick();
    wr_en = 1'b0;
    if (r < ROWS && c < COLS) model[r][c] = d;
  endtask

  task automatic fill(input int offset);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        write_cell(r, c, (r + c + offset) % 16);
  endtask

  // Reads every valid cell through the video path at a random pixel inside the tile.
  task automatic verify_all(input string tag);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        hpos       = 9'(c * 16 + $urandom_range(0, 15));
        vpos       = 9'(r * 16 + $urandom_range(0, 15));
        display_on = 1'b1;
        tick();
        check(tag, digit, model[r][c]);
      end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Expected values assume the store holds (row + col) % 16 when the table runs.
    vecs[0]  = '{1'b1, 4'd2,  4'd5,  4'd9,  9'h000, 9'h000, 1'b0, 4'd0,  3'd0, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  4'd0,  4'd0,  9'd80,  9'd32,  1'b1, 4'd9,  3'd0, 3'd0, 1'b1};
    vecs[2]  = '{1'b0, 4'd0,  4'd0,  4'd0,  9'h05E, 9'h02C, 1'b0, 4'd9,  3'd7, 3'd6, 1'b0};
    vecs[3]  = '{1'b1, 4'd3,  4'd4,  4'd12, 9'h040, 9'h030, 1'b1, 4'd7,  3'd0, 3'd0, 1'b1};
    vecs[4]  = '{1'b0, 4'd0,  4'd0,  4'd0,  9'h040, 9'h030, 1'b1, 4'd12, 3'd0, 3'd0, 1'b1};
    vecs[5]  = '{1'b1, 4'd15, 4'd0,  4'd7,  9'h000, 9'h0E0, 1'b1, 4'd14, 3'd0, 3'd0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0,  4'd0,  4'd0,  9'h1A5, 9'h012, 1'b1, 4'd11, 3'd2, 3'd1, 1'b1};
    vecs[7]  = '{1'b1, 4'd14, 4'd15, 4'd1,  9'h0FF, 9'h0EF, 1'b1, 4'd13, 3'd7, 3'd7, 1'b1};
    vecs[8]  = '{1'b0, 4'd0,  4'd0,  4'd0,  9'h0FF, 9'h0EF, 1'b1, 4'd1,  3'd7, 3'd7, 1'b1};
    vecs[9]  = '{1'b1, 4'd0,  4'd0,  4'd15, 9'h00F, 9'h00E, 1'b1, 4'd0,  3'd7, 3'd7, 1'b1};
    vecs[10] = '{1'b0, 4'd0,  4'd0,  4'd0,  9'h001, 9'h001, 1'b0, 4'd15, 3'd0, 3'd0, 1'b0};

    // Reset state, including display_on held high while reset is asserted.
    #2 reset = 1'b1;
    #1;
    check("rst_digit", digit, 0);
    check("rst_yoff", digit_yoff, 0);
    check("rst_xoff", digit_xoff, 0);
    check("rst_tile_on", tile_on, 0);
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_wr_ready", wr_ready, 1);
    display_on = 1'b1;
    hpos       = 9'h0FF;
    vpos       = 9'h0EF;
    tick();
    tick();
    check("rst_hold_tile_on", tile_on, 0);
    check("rst_hold_xoff", digit_xoff, 0);
    reset = 1'b0;

    fill(0);

    // Vector table, applied one record per cycle.
    for (int i = 0; i < 11; i++) begin
      wr_en      = vecs[i].wr_en;
      wr_row     = vecs[i].wr_row;
      wr_col     = vecs[i].wr_col;
      wr_data    = vecs[i].wr_data;
      hpos       = vecs[i].hpos;
      vpos       = vecs[i].vpos;
      display_on = vecs[i].disp;
      tick();
      if (vecs[i].wr_en && vecs[i].wr_row < ROWS && vecs[i].wr_col < COLS)
        model[vecs[i].wr_row][vecs[i].wr_col] = int'(vecs[i].wr_data);
      check("vec_digit", digit, vecs[i].exp_digit);
      check("vec_xoff", digit_xoff, vecs[i].exp_xoff);
      check("vec_yoff", digit_yoff, vecs[i].exp_yoff);
      check("vec_tile_on", tile_on, vecs[i].exp_on);
    end
    wr_en = 1'b0;

    // The dropped row-15 write must not surface anywhere.
    hpos = 9'h000;
    vpos = 9'h0F0;
    tick();
    check("row15_not_written", (digit == 4'd7) ? 1 : 0, 0);
    verify_all("after_row15_drop");

    // Row 0 holds its column index; sweep one full line.
    for (int c = 0; c < COLS; c++) write_cell(0, c, c);
    vpos       = 9'h000;
    display_on = 1'b1;
    for (int h = 0; h < 256; h++) begin
      hpos = 9'(h);
      tick();
      check("sweep_digit", digit, h / 16);
      check("sweep_xoff", digit_xoff, (h % 16) / 2);
    end

    // Randomized traffic against the cell-array model.
    begin : random_phase
      int  r, c, d, h, v, exp_d;
      logic we, disp;
      for (int i = 0; i < 300; i++) begin
        we    = 1'($urandom_range(0, 1));
        r     = $urandom_range(0, 15);
        c     = $urandom_range(0, 15);
        d     = $urandom_range(0, 15);
        h     = $urandom_range(0, 511);
        v     = $urandom_range(0, 16 * ROWS - 1);
        disp  = 1'($urandom_range(0, 1));
        exp_d = model[v / 16][(h % 256) / 16];
        wr_en = we; wr_row = 4'(r); wr_col = 4'(c); wr_data = 4'(d);
        hpos = 9'(h); vpos = 9'(v); display_on = disp;
        tick();
        if (we && r < ROWS && c < COLS) model[r][c] = d;
        check("rand_digit", digit, exp_d);
        check("rand_xoff", digit_xoff, (h % 16) / 2);
        check("rand_yoff", digit_yoff, (v % 16) / 2);
        check("rand_tile_on", tile_on, disp);
      end
      wr_en = 1'b0;
    end

`ifdef DIGIT_TILE_CLEAR_EN
    begin : clear_phase
      int busy_cycles, done_pulses, done_at_fall, old_last;
      old_last  = model[ROWS - 1][COLS - 1];
      clr_value = 4'd3;
      clr_req   = 1'b1;
      tick();
      clr_req   = 1'b0;
      clr_value = 4'd7;
      check("clr_busy_start", busy, 1);
      check("clr_wr_ready_low", wr_ready, 0);
      check("clr_done_early", clr_done, 0);
      busy_cycles  = 1;
      done_pulses  = 0;
      done_at_fall = 0;
      for (int i = 0; i < 1000 && busy; i++) begin
        wr_en = (i == 10);
        wr_row = 4'd0; wr_col = 4'd0; wr_data = 4'd15;
        clr_req = (i == 20);
        hpos = (i == 150) ? 9'h000 : 9'h0F0;
        vpos = (i == 150) ? 9'h000 : 9'(16 * ROWS - 16);
        display_on = 1'b1;
        tick();
        if (i == 100) check("clr_partial_old", digit, old_last);
        if (i == 150) check("clr_partial_new", digit, 3);
        if (clr_done) done_pulses++;
        if (busy) busy_cycles++;
        else done_at_fall = clr_done;
      end
      wr_en   = 1'b0;
      clr_req = 1'b0;
      check("clr_terminated", busy, 0);
      check("clr_busy_cycles", busy_cycles, ROWS * COLS);
      check("clr_done_with_fall", done_at_fall, 1);
      for (int i = 0; i < 5; i++) begin
        tick();
        if (clr_done) done_pulses++;
        check("clr_idle_after", busy, 0);
      end
      check("clr_done_pulses", done_pulses, 1);
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) model[r][c] = 3;
      verify_all("after_clear");

      // Abort a clear with reset after 100 cells.
      fill(5);
      clr_value = 4'd10;
      clr_req   = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_clr_done", clr_done, 0);
      check("abort_digit", digit, 0);
      check("abort_wr_ready", wr_ready, 1);
      tick();
      tick();
      reset = 1'b0;
      done_pulses = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (clr_done) done_pulses++;
        check("abort_idle", busy, 0);
      end
      check("abort_no_done", done_pulses, 0);
      for (int k = 0; k < 100; k++) model[k / COLS][k % COLS] = 10;
      verify_all("after_abort");
    end
`else
    begin : no_clear_phase
      clr_value = 4'd3;
      clr_req   = 1'b1;
      tick();
      clr_req = 1'b0;
      check("noclr_busy", busy, 0);
      check("noclr_wr_ready", wr_ready, 1);
      check("noclr_done", clr_done, 0);
      for (int i = 0; i < 5; i++) begin
        tick();
        check("noclr_busy_hold", busy, 0);
        check("noclr_ready_hold", wr_ready, 1);
        check("noclr_done_hold", clr_done, 0);
      end
      verify_all("noclr_cells");
      write_cell(1, 1, 6);
      verify_all("noclr_write");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
